// File: rtl/count_seq_checker.sv
// Watches an up-counter's Y output and its toggle-enable, predicts the next value,
// locks after LOCK_CNT consecutive correct predictions, and flags errors and wraps.
module count_seq_checker #(
  parameter int WIDTH    = 3,
  parameter int LOCK_CNT = 2,
  parameter int STAT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [WIDTH-1:0]  y_in,
  input  logic              clr_stat,
  output logic              locked,
  output logic              err,
  output logic              wrap,
  output logic [WIDTH-1:0]  expected,
  output logic [STAT_W-1:0] err_count,
  output logic [STAT_W-1:0] wrap_count
);

  localparam int CW = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {IDLE, SYNC, LOCKED} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       match_cnt_q, match_cnt_d, cnt_inc;
  logic [WIDTH-1:0]    last_y_q, expected_q, expected_d;
  logic                last_en_q;
  logic                locked_q, err_q, err_d, wrap_q, wrap_d;
  logic [STAT_W-1:0]   err_count_q, err_count_d, wrap_count_q, wrap_count_d;
  logic                match;

  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    err_d       = 1'b0;
    wrap_d      = 1'b0;
    cnt_inc     = match_cnt_q + CW'(1);
    match       = (y_in == expected_q);
    // Prediction always restarts from the value actually seen, even on a mismatch.
    expected_d  = y_in + WIDTH'(en);

    case (state_q)
      IDLE: begin
        state_d     = SYNC;
        match_cnt_d = '0;
      end
      SYNC: begin
        if (match) begin
          match_cnt_d = cnt_inc;
          if (cnt_inc == CW'(LOCK_CNT)) state_d = LOCKED;
        end else begin
          match_cnt_d = '0;
        end
      end
      LOCKED: begin
        if (!match) begin
          err_d       = 1'b1;
          state_d     = SYNC;
          match_cnt_d = '0;
        end else if ((&last_y_q) && last_en_q && (y_in == '0)) begin
          wrap_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    err_count_d = err_count_q;
    if (clr_stat)                          err_count_d = '0;
    else if (err_d && (err_count_q != '1)) err_count_d = err_count_q + STAT_W'(1);

    wrap_count_d = wrap_count_q;
    if (clr_stat)                            wrap_count_d = '0;
    else if (wrap_d && (wrap_count_q != '1)) wrap_count_d = wrap_count_q + STAT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      match_cnt_q  <= '0;
      last_y_q     <= '0;
      last_en_q    <= 1'b0;
      expected_q   <= '0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      wrap_q       <= 1'b0;
      err_count_q  <= '0;
      wrap_count_q <= '0;
    end else begin
      state_q      <= state_d;
      match_cnt_q  <= match_cnt_d;
      last_y_q     <= y_in;
      last_en_q    <= en;
      expected_q   <= expected_d;
      locked_q     <= (state_d == LOCKED);
      err_q        <= err_d;
      wrap_q       <= wrap_d;
      err_count_q  <= err_count_d;
      wrap_count_q <= wrap_count_d;
    end
  end

  assign locked     = locked_q;
  assign err        = err_q;
  assign wrap       = wrap_q;
  assign expected   = expected_q;
  assign err_count  = err_count_q;
  assign wrap_count = wrap_count_q;

endmodule

// File: doc/count_seq_checker.md
COUNT_SEQ_CHECKER -- requirements
Module: count_seq_checker

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3, giving the width of the monitored count value.
REQ-002 The block SHALL have parameter LOCK_CNT, default 2, giving the number of consecutive correct predictions needed to lock.
REQ-003 The block SHALL have parameter STAT_W, default 8, giving the width of the error and wrap statistics counters.
REQ-004 The block SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-005 Port clk, input, 1 bit: rising-edge clock, shared with the monitored counter.
REQ-006 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port en, input, 1 bit: toggle-enable driven into the monitored counter's T0 input.
REQ-008 Port y_in, input, WIDTH bits: count value (Y) from the monitored counter.
REQ-009 Port clr_stat, input, 1 bit: synchronous clear of the statistics counters.
REQ-010 Port locked, output, 1 bit: high while the state is LOCKED.
REQ-011 Port err, output, 1 bit: one-cycle pulse on a sequence violation while locked.
REQ-012 Port wrap, output, 1 bit: one-cycle pulse on a locked all-ones to zero transition.
REQ-013 Port expected, output, WIDTH bits: the predicted y_in value for the next sample.
REQ-014 Port err_count, output, STAT_W bits: saturating count of err pulses.
REQ-015 Port wrap_count, output, STAT_W bits: saturating count of wrap pulses.

Function
REQ-016 The block SHALL sample y_in and en on every rising clk edge; all outputs SHALL be registered.
REQ-017 The prediction SHALL be expected = (last_y + last_en) mod 2^WIDTH, where last_y and last_en are the values sampled at the previous edge.
REQ-018 The FSM SHALL have the states IDLE, SYNC and LOCKED.
REQ-019 IDLE: at the first edge after reset release, the block SHALL capture last_y/last_en, clear match_cnt, and go to SYNC; no comparison is made in IDLE.
REQ-020 SYNC, on a match: match_cnt SHALL increment; when match_cnt reaches LOCK_CNT, the state SHALL go to LOCKED and locked SHALL assert at that edge.
REQ-021 SYNC, on a mismatch: match_cnt SHALL return to 0, the state SHALL stay in SYNC, and err SHALL stay low.
REQ-022 LOCKED, on a mismatch: err SHALL go high for exactly one cycle; err_count SHALL increment; the state SHALL go to SYNC with match_cnt=0; locked SHALL deassert at the same edge.
REQ-023 LOCKED, on a match where last_y = all-ones, last_en = 1 and y_in = 0: wrap SHALL pulse for one cycle and wrap_count SHALL increment.
REQ-024 last_y/last_en SHALL update on every edge in every state, including the edge on which a mismatch is detected, so that resynchronization starts from the actual value.
REQ-025 err_count and wrap_count SHALL saturate at 2^STAT_W-1 and SHALL NOT wrap.
REQ-026 clr_stat=1 SHALL zero both counters at the next edge; if an increment occurs at the same edge, the clear SHALL take priority and the result SHALL be 0.
REQ-027 The err and wrap pulses themselves SHALL NOT be suppressed by clr_stat.
REQ-028 Toggling en while locked SHALL NOT by itself cause err; only a y_in value that disagrees with the prediction SHALL cause err.

Reset
REQ-029 When reset=0, the block SHALL immediately (asynchronously) force: state=IDLE, locked=0, err=0, wrap=0, expected=0, err_count=0, wrap_count=0, match_cnt=0, last_y=0, last_en=0.
REQ-030 Reset asserted mid-operation SHALL discard lock and statistics; after release, the block SHALL relock only via IDLE -> SYNC -> LOCKED.

Verification
REQ-031 Normal lock: release reset, then en=1 with the counter counting 0,1,2,... -> locked=1 at the 3rd edge after release (IDLE + 2 matches), and err never asserts over 20 cycles.
REQ-032 Wrap: locked, counter steps 6,7,0 with en=1 -> a single wrap pulse on the edge sampling 0, and wrap_count increments from 0 to 1.
REQ-033 Hold: locked, en=0 for 5 cycles with y_in held at 4 -> no err, expected=4 throughout.
REQ-034 Fault: locked with last_y=3 and last_en=1, force y_in=5 -> err pulses for one cycle, err_count=1, locked=0; the correct sequence afterwards (6,7) gives locked=1 two edges later.
REQ-035 Saturation and clear: inject 260 faults with STAT_W=8 -> err_count=255; then clr_stat=1 at the same edge as a fault -> err_count=0 and err still pulses.
REQ-036 Async reset: assert reset=0 between clock edges while locked with err_count=3 -> all outputs are 0 immediately, without waiting for a clk edge.
